conv_out_axis_sink: RTL and testbench
=====================================

Name: conv_out_axis_sink

Overview:
- AXI-Stream slave that receives the convolution engine's 64-bit result stream (4 x 16-bit pixels per beat) for one output channel.
- Writes each beat as one word into the output feature BRAM write port.
- Sits downstream of the conv master port, between the conv datapath and the output BRAM / DMA.
- Provides a 2-entry skid FIFO, frame-length counting, TLAST checking and a done pulse for the system controller.

Parameters:
DATA_WIDTH, 64, stream and BRAM word width (4 pixels).
PIXEL_WIDTH, 16, width of one packed pixel; DATA_WIDTH/PIXEL_WIDTH = 4.
ADDR_WIDTH, 14, output BRAM word address width.

Ports:
clk  in  1  system clock; all logic rising-edge.
aresetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; arms reception of one frame.
IMAGE_SIZE_choose  in  3  0=4, 1=8, 2=16, 3=32, 4=64, 5=128; 6/7 reserved, treated as 4.
s_axis_tdata  in  64  result beat, pixel0 in [15:0].
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  last beat of frame.
s_axis_tready  out  1  sink can accept a beat.
bram_wr_ready  in  1  BRAM port/arbiter accepts a write this cycle.
bram_we  out  1  write strobe.
bram_addr  out  ADDR_WIDTH  word address.
bram_din  out  64  write data.
busy  out  1  high from start accept until done.
done  out  1  one-cycle pulse when the last word has been written.
tlast_err  out  1  sticky TLAST mismatch flag, cleared on next accepted start.
beat_count  out  ADDR_WIDTH  beats accepted in the current frame.

Behaviour:
- Reset (async, aresetn=0): state IDLE, FIFO empty.
  - All outputs 0: s_axis_tready, bram_we, bram_addr, bram_din, busy, done, tlast_err, beat_count.
  - Release is synchronous to the next clk edge.
- Frame length: N = decoded image size; expected beats E = N*N/4 (4..4096); last beat index E-1.
- FSM states: IDLE, RECV, FLUSH, DONE.
  - IDLE: on start=1, latch E, clear beat_count, write address and tlast_err; go to RECV next cycle.
  - RECV: s_axis_tready = (FIFO count < 2). A beat is accepted when tvalid && tready and is pushed to the FIFO; beat_count increments. When the accepted beat is index E-1, go to FLUSH; tready is 0 from the next cycle.
  - FLUSH: tready=0. Go to DONE once the FIFO is empty, including the cycle of the final write.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle; go to IDLE.
- start is ignored outside IDLE.
- busy=1 in RECV and FLUSH.
- Write side:
  - bram_we = FIFO non-empty && bram_wr_ready.
  - bram_din = FIFO head; bram_addr = write address counter.
  - On each write: pop the FIFO and increment the address.
  - Combinational from registered state; no combinational path from s_axis_* to bram_*.
- FIFO push and pop in the same cycle are allowed: count is unchanged, data order is preserved.
- Throughput: 1 beat/cycle sustained when bram_wr_ready=1.
- Latency: accepted beat appears on bram_din the next cycle.
- Backpressure: bram_wr_ready=0 for 2+ cycles fills the FIFO and drops tready; no beat is lost or duplicated.
- Early tlast does not end the frame; length is always E beats.
- Address does not wrap within a frame; max address used is E-1 = 4095 < 2^ADDR_WIDTH.
- Reset mid-frame: everything is cleared immediately; partially written BRAM contents are don't-care.

Optional Feature:
- CONV_SINK_TLAST_CHECK_EN defined: tlast_err is set if tlast=1 on an accepted beat with index != E-1, or tlast=0 on beat E-1. It stays set until the next accepted start.
- Undefined: tlast is ignored and tlast_err is tied to 0.

Decomposition:
- Shared package (conv_pkg): IMAGE_SIZE_choose encodings, an image-size decode function returning N and E, FSM state encoding localparams.
- One sub-module, conv_sink_skid_fifo: 2-entry DATA_WIDTH FIFO with push/pop/full/empty/count.

Test Plan:
1. Size 4, tvalid=1 and bram_wr_ready=1 continuous: 4 beats 0x..0001..0x..0004 -> writes to addr 0..3 on consecutive cycles; done pulses 1 cycle after the last write; tlast_err=0.
2. Size 128, random tvalid gaps: exactly 4096 writes, address 0..4095 in order, data matches, beat_count=4096 at done.
3. Size 8 (16 beats), bram_wr_ready=0 for cycles 3..7: tready drops after the FIFO holds 2 beats; no loss or duplication; done only after the 16th write.
4. With CONV_SINK_TLAST_CHECK_EN, size 4, tlast on beat 1 -> tlast_err=1 and 4 writes still occur; next start clears tlast_err.
5. aresetn=0 while in RECV after 2 of 16 beats -> all outputs 0 immediately; a new start then runs a full frame from addr 0.
6. start pulsed in RECV and FLUSH -> ignored; only one done pulse per frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output sink: widths, image-size
// encodings with their decode, and the sink FSM state encoding.
package conv_pkg;

  localparam int unsigned DATA_WIDTH      = 64;
  localparam int unsigned PIXEL_WIDTH     = 16;
  localparam int unsigned PIXELS_PER_BEAT = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned ADDR_WIDTH      = 14;
  localparam int unsigned SIZE_SEL_WIDTH  = 3;
  localparam int unsigned DIM_WIDTH       = 8;
  localparam int unsigned FIFO_CNT_WIDTH  = 2;

  typedef enum logic [SIZE_SEL_WIDTH-1:0] {
    IMG_4   = 3'd0,
    IMG_8   = 3'd1,
    IMG_16  = 3'd2,
    IMG_32  = 3'd3,
    IMG_64  = 3'd4,
    IMG_128 = 3'd5
  } img_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_e;

  typedef struct packed {
    logic [DIM_WIDTH-1:0]  n;
    logic [ADDR_WIDTH-1:0] e;
  } img_dims_t;

  // Side length N and beats per frame E = N*N/4; reserved codes fall back to 4x4.
  function automatic img_dims_t decode_image_size(input logic [SIZE_SEL_WIDTH-1:0] sel);
    img_dims_t   d;
    int unsigned n;
    case (sel)
      IMG_8:   n = 8;
      IMG_16:  n = 16;
      IMG_32:  n = 32;
      IMG_64:  n = 64;
      IMG_128: n = 128;
      default: n = 4;
    endcase
    d.n = DIM_WIDTH'(n);
    d.e = ADDR_WIDTH'((n * n) / PIXELS_PER_BEAT);
    return d;
  endfunction

endpackage

// File: rtl/conv_out_axis_sink_if.sv
// AXI-Stream result channel from the convolution datapath into the output sink.
interface conv_out_axis_sink_if;

  logic [conv_pkg::DATA_WIDTH-1:0] tdata;
  logic                            tvalid;
  logic                            tlast;
  logic                            tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/conv_sink_skid_fifo.sv
// Two-entry skid FIFO between the stream acceptor and the BRAM write port.
module conv_sink_skid_fifo
  import conv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      full,
  output logic                      empty,
  output logic [FIFO_CNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == FIFO_CNT_WIDTH'(0));
  assign full    = (count == FIFO_CNT_WIDTH'(2));
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a beat when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_WIDTH'(1);
        2'b01:   count <= count - FIFO_CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_axis_sink.sv
// Convolution result sink: receives one output-channel frame over AXI-Stream and writes
// it word by word into the output BRAM. Define CONV_SINK_TLAST_CHECK_EN to enable tlast_err.
module conv_out_axis_sink
  import conv_pkg::*;
(
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic [SIZE_SEL_WIDTH-1:0] IMAGE_SIZE_choose,
  conv_out_axis_sink_if.slave       s_axis,
  input  logic                      bram_wr_ready,
  output logic                      bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [DATA_WIDTH-1:0]     bram_din,
  output logic                      busy,
  output logic                      done,
  output logic                      tlast_err,
  output logic [ADDR_WIDTH-1:0]     beat_count
);

  sink_state_e               state;
  logic [ADDR_WIDTH-1:0]     exp_beats;
  img_dims_t                 size;
  logic                      accept;
  logic                      last_beat;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_CNT_WIDTH-1:0] fifo_count;
  logic                      unused_dim;

  assign size       = decode_image_size(IMAGE_SIZE_choose);
  assign unused_dim = ^size.n;

  assign s_axis.tready = (state == ST_RECV) && !fifo_full;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign last_beat     = (beat_count == exp_beats - ADDR_WIDTH'(1));
  // Write side depends only on registered FIFO state and the arbiter grant.
  assign bram_we       = !fifo_empty && bram_wr_ready;

  conv_sink_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (aresetn),
    .push  (accept),
    .din   (s_axis.tdata),
    .pop   (bram_we),
    .dout  (bram_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencing, beat/address counters and the busy/done strobes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      exp_beats  <= '0;
      beat_count <= '0;
      bram_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bram_we) begin
        bram_addr <= bram_addr + ADDR_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_beats  <= size.e;
            beat_count <= '0;
            bram_addr  <= '0;
            busy       <= 1'b1;
            state      <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (accept) begin
            beat_count <= beat_count + ADDR_WIDTH'(1);
            if (last_beat) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Leave as soon as the final word is being written.
          if (fifo_empty || (fifo_count == FIFO_CNT_WIDTH'(1) && bram_we)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SINK_TLAST_CHECK_EN
  // Sticky: tlast must mark exactly beat E-1 of the frame.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tlast_err <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      tlast_err <= 1'b0;
    end else if (accept && (s_axis.tlast != last_beat)) begin
      tlast_err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
  assign tlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_out_axis_sink.sv
// Bench for conv_out_axis_sink: frame-level occupancy model checked every cycle, plus
// directed frames covering sizes, stalls, gaps, tlast errors, mid-frame reset and stray starts.
module tb_conv_out_axis_sink;
  import conv_pkg::*;

`ifdef CONV_SINK_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  aresetn;
  logic                  start;
  logic [2:0]            image_size;
  logic                  bram_wr_ready;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  busy;
  logic                  done;
  logic                  tlast_err;
  logic [ADDR_WIDTH-1:0] beat_count;

  conv_out_axis_sink_if axis ();

  conv_out_axis_sink dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .start             (start),
    .IMAGE_SIZE_choose (image_size),
    .s_axis            (axis),
    .bram_wr_ready     (bram_wr_ready),
    .bram_we           (bram_we),
    .bram_addr         (bram_addr),
    .bram_din          (bram_din),
    .busy              (busy),
    .done              (done),
    .tlast_err         (tlast_err),
    .beat_count        (beat_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input int frame, input int k);
    return {16'(16'hA000 + frame), 16'(k * 3), 16'(~k), 16'(k + 1)};
  endfunction

  // Frame model: beats accepted / words written, FIFO occupancy is their difference.
  int e_tab [8] = '{4, 16, 64, 256, 1024, 4096, 4, 4};
  bit m_active = 1'b0;
  bit m_done_next = 1'b0;
  bit m_terr = 1'b0;
  int m_acc = 0;
  int m_wr = 0;
  int m_e = 0;
  int m_frames = 0;
  int cur_frame = 0;
  int cyc = 0;
  int t_first_wr = 0;
  int t_last_wr = 0;
  int t_done = 0;

  always @(negedge clk) begin : compare
    int occ;
    bit exp_tready;
    bit exp_we;
    bit idle;
    cyc++;
    if (!aresetn) begin
      chk("rst_tready", 64'(axis.tready), 64'd0);
      chk("rst_we", 64'(bram_we), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_din", bram_din, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_tlast_err", 64'(tlast_err), 64'd0);
      chk("rst_beat_count", 64'(beat_count), 64'd0);
      m_active = 1'b0; m_done_next = 1'b0; m_terr = 1'b0;
      m_acc = 0; m_wr = 0;
    end else begin
      idle       = !m_active && !m_done_next;
      occ        = m_acc - m_wr;
      exp_tready = m_active && (m_acc < m_e) && (occ < 2);
      exp_we     = (occ > 0) && bram_wr_ready;
      chk("tready", 64'(axis.tready), 64'(exp_tready));
      chk("bram_we", 64'(bram_we), 64'(exp_we));
      chk("bram_addr", 64'(bram_addr), 64'(m_wr));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done_next));
      chk("beat_count", 64'(beat_count), 64'(m_acc));
      chk("tlast_err", 64'(tlast_err), 64'(m_terr));
      if (exp_we && bram_we) chk("bram_din", bram_din, beat_data(cur_frame, m_wr));
      if (m_done_next) begin
        m_done_next = 1'b0;
        m_frames++;
        t_done = cyc;
      end
      if (exp_tready && axis.tvalid) begin
        if (TLAST_CHK && (axis.tlast != (m_acc == m_e - 1))) m_terr = 1'b1;
        m_acc++;
      end
      if (exp_we) begin
        if (m_wr == 0) t_first_wr = cyc;
        t_last_wr = cyc;
        m_wr++;
        if (m_wr == m_e) begin
          m_active    = 1'b0;
          m_done_next = 1'b1;
        end
      end
      if (start && idle) begin
        m_active = 1'b1; m_terr = 1'b0;
        m_acc = 0; m_wr = 0;
        m_e = e_tab[image_size];
      end
    end
  end

  // Drives one frame; stall/start/reset cycles are counted from the first RECV cycle.
  task automatic run_frame(input int sz, input bit gaps, input int stall_lo, input int stall_hi,
                           input int bad_tlast, input int st1, input int st2, input int reset_at);
    int base;
    bit fin;
    @(posedge clk); #1;
    cur_frame     = cur_frame + 1;
    image_size    = 3'(sz);
    start         = 1'b1;
    axis.tvalid   = 1'b0;
    bram_wr_ready = 1'b1;
    base = m_frames;
    fin  = 1'b0;
    for (int c = 0; c < 12000 && !fin; c++) begin
      @(posedge clk); #1;
      start         = (c == st1) || (c == st2);
      bram_wr_ready = !(c >= stall_lo && c <= stall_hi);
      if (m_frames != base) begin
        fin = 1'b1; start = 1'b0; axis.tvalid = 1'b0; bram_wr_ready = 1'b1;
      end else if (reset_at >= 0 && m_acc == reset_at) begin
        aresetn = 1'b0; start = 1'b0; axis.tvalid = 1'b0;
        #1;
        chk("rst_now_tready", 64'(axis.tready), 64'd0);
        chk("rst_now_we", 64'(bram_we), 64'd0);
        chk("rst_now_addr", 64'(bram_addr), 64'd0);
        chk("rst_now_din", bram_din, 64'd0);
        chk("rst_now_busy", 64'(busy), 64'd0);
        chk("rst_now_beat_count", 64'(beat_count), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        fin = 1'b1;
      end else begin
        axis.tvalid = (m_acc < m_e) && !(gaps && $urandom_range(0, 3) == 0);
        axis.tdata  = beat_data(cur_frame, m_acc);
        axis.tlast  = (bad_tlast >= 0) ? (m_acc == bad_tlast) : (m_acc == m_e - 1);
      end
    end
    if (!fin) chk("frame_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int f0;
    aresetn = 1'b0; start = 1'b0; image_size = 3'd0; bram_wr_ready = 1'b0;
    axis.tvalid = 1'b0; axis.tdata = '0; axis.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;

    // 1: 4x4 frame, continuous stream
    f0 = m_frames;
    run_frame(0, 1'b0, -1, -1, -1, -1, -1, -1);
    chk("t1_frames", 64'(m_frames - f0), 64'd1);
    chk("t1_addr_end", 64'(bram_addr), 64'd4);
    chk("t1_beat_count", 64'(beat_count), 64'd4);
    chk("t1_write_span", 64'(t_last_wr - t_first_wr), 64'd3);
    chk("t1_done_lag", 64'(t_done - t_last_wr), 64'd1);
    chk("t1_tlast_err", 64'(tlast_err), 64'd0);

    // 2: 128x128 frame with random tvalid gaps
    run_frame(5, 1'b1, -1, -1, -1, -1, -1, -1);
    chk("t2_addr_end", 64'(bram_addr), 64'd4096);
    chk("t2_beat_count", 64'(beat_count), 64'd4096);

    // 3: 8x8 frame, BRAM port stalled for cycles 3..7
    f0 = m_frames;
    run_frame(1, 1'b0, 3, 7, -1, -1, -1, -1);
    chk("t3_frames", 64'(m_frames - f0), 64'd1);
    chk("t3_addr_end", 64'(bram_addr), 64'd16);
    chk("t3_beat_count", 64'(beat_count), 64'd16);

    // 4: early tlast on beat 1, then a clean frame clears the flag
    run_frame(0, 1'b0, -1, -1, 1, -1, -1, -1);
    chk("t4_tlast_err", 64'(tlast_err), 64'(TLAST_CHK));
    chk("t4_addr_end", 64'(bram_addr), 64'd4);
    run_frame(0, 1'b0, -1, -1, -1, -1, -1, -1);
    chk("t4_tlast_err_cleared", 64'(tlast_err), 64'd0);

    // 5: reset after 2 of 16 beats, then a full frame
    run_frame(1, 1'b0, -1, -1, -1, -1, -1, 2);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    run_frame(1, 1'b0, -1, -1, -1, -1, -1, -1);
    chk("t5_addr_end", 64'(bram_addr), 64'd16);

    // 6: stray starts in RECV (cycle 1) and FLUSH (cycle 5)
    f0 = m_frames;
    run_frame(0, 1'b0, 4, 6, -1, 1, 5, -1);
    repeat (4) @(posedge clk);
    chk("t6_frames", 64'(m_frames - f0), 64'd1);
    chk("t6_addr_end", 64'(bram_addr), 64'd4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
